// File: rtl/fwft_prefetch.sv
// First-word-fall-through adapter in front of a standard-mode FIFO.
// Prefetches up to two words (head + skid) so dout is valid before the consumer pops.
module fwft_prefetch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [1:0]            count
);

  logic [1:0]            cnt;
  logic                  empty_q;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;
  logic                  pop;
  logic [2:0]            occ_next;

  // Issue only while the words already owned, minus this pop, leave a free slot.
  always_comb begin
    pop      = rd & ~empty_q;
    occ_next = {1'b0, cnt} + {2'b00, vld_p1} - {2'b00, pop};
    fifo_rd  = ~rst & ~fifo_empty & (occ_next <= 3'd1);
  end

  // Stage p1: upstream data arrives one cycle after fifo_rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      empty_q <= 1'b1;
      vld_p1  <= 1'b0;
      head    <= '0;
    end else begin
      cnt     <= occ_next[1:0];
      empty_q <= (occ_next == 3'd0);
      vld_p1  <= fifo_rd;
      case (cnt)
        2'd0: begin
          if (vld_p1) head <= fifo_rd_data;
        end
        2'd1: begin
          if (vld_p1 && pop)       head <= fifo_rd_data;
          else if (vld_p1 && !pop) skid <= fifo_rd_data;
        end
        2'd2: begin
          if (pop) begin
            head <= skid;
            if (vld_p1) skid <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(vld_p1 && (cnt == 2'd2) && !pop));
      assert (cnt <= 2'd2);
      assert (!(fifo_rd && fifo_empty));
    end
  end

  assign dout  = head;
  assign empty = empty_q;
  assign count = cnt;

endmodule

// File: tb/tb_fwft_prefetch.sv
// Bench for fwft_prefetch: queue-based upstream FIFO, word-order reference model,
// directed vector table plus randomized push/pop traffic.
module tb_fwft_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rd;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty;
  logic        rd;
  logic [31:0] dout;
  logic        empty;
  logic [1:0]  count;

  fwft_prefetch #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .fifo_rd(fifo_rd), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .rd(rd), .dout(dout), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          push_n;
    logic [31:0] push_val;
    logic        rd;
    logic        e_frd;
    logic        e_empty;
    logic [1:0]  e_cnt;
    logic [31:0] e_dout;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] up_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pop_log[$];
  int          pop_cyc[$];
  int          m_cnt, m_inf;
  int          errors, checks, cyc;
  bit          chk_en, clr_up;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] w);
    up_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic cycle(input logic rd_v);
    logic fr, e_fr, e_pop;
    rd = rd_v;
    #1;
    fr    = fifo_rd;
    e_pop = rd_v && (m_cnt > 0);
    e_fr  = !rst && !fifo_empty && ((m_cnt + m_inf - int'(e_pop)) <= 1);
    if (chk_en) begin
      check("fifo_rd", 32'(fr), 32'(e_fr));
      check("empty", 32'(empty), 32'(m_cnt == 0));
      check("count", 32'(count), 32'(m_cnt));
      check("rd_while_up_empty", 32'(fr & fifo_empty), 32'd0);
      if (m_cnt > 0 && exp_q.size() > 0) check("dout", dout, exp_q[0]);
    end
    if (rst) begin
      for (int i = 0; i < m_cnt + m_inf; i++)
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (clr_up) exp_q.delete();
      m_cnt = 0;
      m_inf = 0;
    end else begin
      if (e_pop) begin
        pop_log.push_back(dout);
        pop_cyc.push_back(cyc);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      m_cnt = m_cnt + m_inf - int'(e_pop);
      m_inf = int'(e_fr);
    end
    @(negedge clk);
    cyc++;
    if (rst && clr_up) up_q.delete();
    else if (fr && up_q.size() > 0) fifo_rd_data = up_q.pop_front();
    fifo_empty = (up_q.size() == 0);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exp_q.size() > 0 || m_cnt > 0) && n < bound) begin
      cycle(1'b1);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    cycle(1'b0);
    cycle(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int pushed, n;
    errors = 0; checks = 0; cyc = 0;
    m_cnt = 0; m_inf = 0;
    chk_en = 1'b0; clr_up = 1'b0;
    rst = 1'b1; rd = 1'b0; fifo_empty = 1'b1; fifo_rd_data = 32'h0;

    // single word, pop, pop on empty; then 5-word back-pressure and release
    vecs[0]  = '{1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0};
    vecs[1]  = '{0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[2]  = '{0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd1, 32'hA5A5_0001};
    vecs[3]  = '{0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd1, 32'hA5A5_0001};
    vecs[4]  = '{0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[5]  = '{0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[6]  = '{0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[7]  = '{5, 32'h1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0};
    vecs[8]  = '{0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0};
    vecs[9]  = '{0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h1};
    vecs[10] = '{0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1};
    vecs[11] = '{0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1};
    vecs[12] = '{0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd2, 32'h1};
    vecs[13] = '{0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h2};
    vecs[14] = '{0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h3};
    vecs[15] = '{0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h4};
    vecs[16] = '{0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h5};
    vecs[17] = '{0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};

    @(negedge clk);
    // reset held two cycles with words waiting upstream
    cycle(1'b0);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h100 + 32'(i));
    cycle(1'b0);
    check("rst_dout", dout, 32'h0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    rst = 1'b0;
    #1;
    check("rd_after_rst", 32'(fifo_rd), 32'd1);
    drain(20);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].push_n; k++) push(vecs[i].push_val + 32'(k));
      rd = vecs[i].rd;
      #1;
      check($sformatf("v%0d_fifo_rd", i), 32'(fifo_rd), 32'(vecs[i].e_frd));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      if (!vecs[i].e_empty) check($sformatf("v%0d_dout", i), dout, vecs[i].e_dout);
      cycle(vecs[i].rd);
    end

    // streaming: 8 words, rd held high
    pop_log.delete(); pop_cyc.delete();
    for (int i = 1; i <= 8; i++) push(32'(i));
    for (int i = 0; i < 12; i++) cycle(1'b1);
    check("stream_n", 32'(pop_log.size()), 32'd8);
    if (pop_log.size() >= 8) begin
      for (int i = 0; i < 8; i++) check($sformatf("stream_w%0d", i), pop_log[i], 32'(i + 1));
      check("stream_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
    end
    cycle(1'b0);

    // random pushes and pops over 64 words
    pushed = 0; n = 0;
    while ((pushed < 64 || exp_q.size() > 0) && n < 3000) begin
      if (pushed < 64 && $urandom_range(0, 1) == 1) begin
        push($urandom);
        pushed++;
      end
      cycle($urandom_range(0, 2) != 0);
      n++;
    end
    check("rand_left", 32'(exp_q.size()), 32'd0);
    cycle(1'b0);
    cycle(1'b0);

    // reset while a word is buffered and another is in flight
    for (int i = 0; i < 6; i++) push(32'h200 + 32'(i));
    cycle(1'b0);
    cycle(1'b0);
    check("pre_rst_count", 32'(count), 32'd1);
    rst = 1'b1; clr_up = 1'b1;
    cycle(1'b0);
    rst = 1'b0; clr_up = 1'b0;
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_count", 32'(count), 32'd0);
    pop_log.delete();
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i));
    drain(20);
    check("post_rst_n", 32'(pop_log.size()), 32'd3);
    if (pop_log.size() > 0) check("post_rst_first", pop_log[0], 32'h300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
